load_store_unit: RTL and testbench
==================================

# load_store_unit

Data-memory access stage placed between the core's execute/memory stage and the data memory. Accepts one load or store per request. Checks alignment, then generates byte strobes and lane-shifted write data. Drives a request/acknowledge memory handshake that tolerates wait states, and returns sign- or zero-extended load data. Holds the pipeline through `o_stall` while an access is in flight, and flags misaligned accesses and memory timeouts through `o_fault`.

## Interface
- `WIDTH`, 32: data width (fixed 32; lanes are bytes).
- `D_ADD_SIZE`, 32: data address width.
- `TIMEOUT`, 255: maximum ACCESS cycles without ack before fault; range 1..255.
- `i_clk`  in  1: clock, rising edge.
- `i_rst`  in  1: asynchronous, active-high reset.
- `i_req`  in  1: access request; sampled only in IDLE.
- `i_we`  in  1: 1 = store, 0 = load.
- `i_funct3`  in  3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
- `i_addr`  in  D_ADD_SIZE: byte address.
- `i_wdata`  in  WIDTH: store data, right-aligned.
- `o_stall`  out  1: freeze upstream pipeline.
- `o_done`  out  1: one-cycle completion pulse.
- `o_rdata`  out  WIDTH: extended load result.
- `o_fault`  out  1: valid with `o_done`; misaligned, illegal funct3, or timeout.
- `o_mem_req`  out  1: memory request, held until ack or timeout.
- `o_mem_we`  out  1: memory write enable.
- `o_mem_addr`  out  D_ADD_SIZE: word-aligned address, bits [1:0] = 0.
- `o_mem_wstrb`  out  4: byte-lane write strobes; 0 for loads.
- `o_mem_wdata`  out  WIDTH: lane-replicated store data.
- `i_mem_ack`  in  1: memory completion; read data valid the same cycle.
- `i_mem_rdata`  in  WIDTH: memory read word.

## Operation
- **FSM states:** IDLE, ACCESS, DONE.
- **IDLE with `i_req`=1:** decode and register addr, we, funct3, strobes and write data.
  - Legal access: go to ACCESS.
  - Misaligned or illegal funct3: go to DONE with the fault flag set; no memory request is issued.
- **Misaligned:**
  - H/HU with addr[0]=1.
  - W with addr[1:0]≠0.
- **Illegal funct3:** 011, 110 or 111; also BU/HU with `i_we`=1.
- **Store lanes:**
  - B: data[7:0] replicated ×4; wstrb = 1<<addr[1:0].
  - H: {data[15:0], data[15:0]}; wstrb = 0011 if addr[1]=0, else 1100.
  - W: data as-is; wstrb = 1111.
- **Load extract:** word >> (8·addr[1:0]). Sign-extend from bit 7 (B) or bit 15 (H); zero-extend for BU/HU.
- **ACCESS:**
  - `o_mem_req`=1; addr, we, wstrb and wdata stay stable.
  - The 8-bit wait counter starts at 0 on entry and increments each cycle without ack.
  - On ack: capture and extend the load data; go to DONE.
  - Counter == TIMEOUT and no ack: drop req, set fault, go to DONE.
  - Ack and timeout in the same cycle: ack wins, no fault.
- **DONE:** `o_done`=1 for one cycle, then return to IDLE. `i_req` is ignored in DONE.
- **`o_stall`** = (IDLE & `i_req`) | ACCESS. It is combinational and low in DONE, so the pipeline advances in the completion cycle.
- **`o_rdata`:** updated only on a load ack; holds its value across stores and faults.

## Timing
- **Reset values:** all outputs 0, state IDLE, counter 0. Reset mid-ACCESS drops `o_mem_req` immediately (asynchronous); the abandoned transaction is never completed.
- **Zero-wait load/store:**
  - Cycle 0: IDLE accept.
  - Cycle 1: ACCESS with ack.
  - Cycle 2: DONE, `o_rdata` valid.
  - Total latency: 2 cycles + N wait states.
- **Fault (misaligned/illegal):** accept at cycle 0, DONE with `o_fault` at cycle 1; `o_mem_req` never asserts.
- **Timeout:** `o_mem_req` is high for TIMEOUT+1 cycles; DONE with fault follows.
- **Back-to-back requests:** the next request is accepted no earlier than the cycle after DONE, giving a maximum throughput of one access per 3 cycles.
- **`o_mem_*` outputs:** registered, no combinational path from `i_req`. `i_mem_ack` outside ACCESS is ignored.

## Structure
- **Package `lsu_pkg`:**
  - funct3 constants (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU).
  - State enum.
  - TIMEOUT counter width of 8.
- **Sub-module `lsu_align`:** purely combinational. It computes the misaligned/illegal flags, wstrb and replicated wdata, and performs load extraction and extension. The top level holds the FSM, counter and registers.

## Test plan
- LW at 0x100, ack on first ACCESS cycle, rdata 0xDEADBEEF -> `o_done` at cycle 2, `o_rdata`=0xDEADBEEF, `o_fault`=0.
- LB at 0x103, rdata 0x80FF_0000 -> `o_rdata`=0xFFFFFF80. Same access as LBU -> 0x00000080.
- SH at 0x102, wdata 0x1234ABCD -> `o_mem_addr`=0x100, wstrb=1100, `o_mem_wdata`=0xABCDABCD.
- SW at 0x101 -> `o_mem_req` stays 0; `o_done`+`o_fault` at cycle 1; `o_rdata` unchanged.
- LW with ack withheld and TIMEOUT=4 -> req high for 5 cycles, then fault. Repeat with ack on the 5th cycle -> no fault.
- Assert `i_rst` during ACCESS after 2 wait cycles -> `o_mem_req`, `o_stall` and `o_done` all 0 immediately. A new LW accepted after reset completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions.
// funct3 encodings, FSM states and wait-counter width.
package lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    localparam int LSU_CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Store side: fault decode, strobes, replicated data. Load side: extract and extend.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic        st_we,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic        misaligned,
    output logic        illegal,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    assign shifted = ld_word >> {ld_off, 3'b000};

    // Decode the request: legality, alignment, strobes and lane data.
    always_comb begin
        misaligned = 1'b0;
        illegal    = 1'b0;
        wstrb      = 4'b0000;
        wdata      = st_data;
        case (st_funct3)
            LSU_B: begin
                wdata = {4{st_data[7:0]}};
                wstrb = 4'b0001 << st_off;
            end
            LSU_H: begin
                misaligned = st_off[0];
                wdata      = {2{st_data[15:0]}};
                wstrb      = st_off[1] ? 4'b1100 : 4'b0011;
            end
            LSU_W: begin
                misaligned = (st_off != 2'b00);
                wstrb      = 4'b1111;
            end
            LSU_BU: begin
                illegal = st_we;
            end
            LSU_HU: begin
                illegal    = st_we;
                misaligned = st_off[0];
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        if (!st_we) begin
            wstrb = 4'b0000;
        end
    end

    // Pick the addressed lane(s) of the read word and extend.
    always_comb begin
        ld_data = ld_word;
        case (ld_funct3)
            LSU_B:   ld_data = {{24{shifted[7]}}, shifted[7:0]};
            LSU_H:   ld_data = {{16{shifted[15]}}, shifted[15:0]};
            LSU_BU:  ld_data = {24'h0, shifted[7:0]};
            LSU_HU:  ld_data = {16'h0, shifted[15:0]};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: request FSM, wait counter, registered memory port.
// Lane handling lives in lsu_align.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int D_ADD_SIZE = 32,
    parameter int TIMEOUT    = 255
)
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [2:0]            i_funct3,
    input  logic [D_ADD_SIZE-1:0] i_addr,
    input  logic [WIDTH-1:0]      i_wdata,
    output logic                  o_stall,
    output logic                  o_done,
    output logic [WIDTH-1:0]      o_rdata,
    output logic                  o_fault,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [D_ADD_SIZE-1:0] o_mem_addr,
    output logic [3:0]            o_mem_wstrb,
    output logic [WIDTH-1:0]      o_mem_wdata,
    input  logic                  i_mem_ack,
    input  logic [WIDTH-1:0]      i_mem_rdata
);

    localparam logic [LSU_CNT_W-1:0] TMO = LSU_CNT_W'(TIMEOUT);

    lsu_state_t           state_q;
    lsu_state_t           state_d;
    logic [LSU_CNT_W-1:0] cnt_q;
    logic                 fault_q;
    logic [1:0]           off_q;
    logic [2:0]           f3_q;
    logic                 misaligned;
    logic                 illegal;
    logic                 bad;
    logic                 timeout;
    logic [3:0]           wstrb;
    logic [WIDTH-1:0]     wdata;
    logic [WIDTH-1:0]     ld_data;

    lsu_align u_align (
        .st_funct3  (i_funct3),
        .st_we      (i_we),
        .st_off     (i_addr[1:0]),
        .st_data    (i_wdata),
        .misaligned (misaligned),
        .illegal    (illegal),
        .wstrb      (wstrb),
        .wdata      (wdata),
        .ld_funct3  (f3_q),
        .ld_off     (off_q),
        .ld_word    (i_mem_rdata),
        .ld_data    (ld_data)
    );

    assign bad     = misaligned | illegal;
    assign timeout = (cnt_q == TMO);
    assign o_done  = (state_q == S_DONE);
    assign o_fault = o_done & fault_q;
    assign o_stall = ~i_rst & (((state_q == S_IDLE) & i_req)
                               | (state_q == S_ACCESS));

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: faults skip the memory, ack or timeout ends ACCESS.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_req) begin
                    state_d = bad ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (i_mem_ack || timeout) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request capture, memory port, wait counter and load result.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q       <= '0;
            fault_q     <= 1'b0;
            off_q       <= 2'b00;
            f3_q        <= 3'b000;
            o_rdata     <= '0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wstrb <= 4'b0000;
            o_mem_wdata <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (i_req) begin
                        fault_q <= bad;
                        if (!bad) begin
                            off_q       <= i_addr[1:0];
                            f3_q        <= i_funct3;
                            o_mem_req   <= 1'b1;
                            o_mem_we    <= i_we;
                            o_mem_addr  <= {i_addr[D_ADD_SIZE-1:2], 2'b00};
                            o_mem_wstrb <= wstrb;
                            o_mem_wdata <= wdata;
                        end
                    end
                end
                S_ACCESS: begin
                    if (i_mem_ack) begin
                        o_mem_req <= 1'b0;
                        if (!o_mem_we) begin
                            o_rdata <= ld_data;
                        end
                    end else if (timeout) begin
                        o_mem_req <= 1'b0;
                        fault_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a scripted memory responder.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req;
    logic        i_we;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_stall;
    logic        o_done;
    logic [31:0] o_rdata;
    logic        o_fault;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [3:0]  o_mem_wstrb;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    int n_chk = 0;
    int n_err = 0;

    load_store_unit #(
        .WIDTH      (32),
        .D_ADD_SIZE (32),
        .TIMEOUT    (4)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .i_we        (i_we),
        .i_funct3    (i_funct3),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_stall     (o_stall),
        .o_done      (o_done),
        .o_rdata     (o_rdata),
        .o_fault     (o_fault),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wstrb (o_mem_wstrb),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One access. ack_at = index of the ACCESS cycle that acks (-1: never).
    task automatic run(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] mrd, input int ack_at,
                       output int done_cyc, output int req_cyc,
                       output logic flt, output logic [3:0] strb,
                       output logic [31:0] maddr, output logic [31:0] mwd);
        int cyc;
        done_cyc = -1;
        req_cyc  = 0;
        flt      = 1'b0;
        strb     = 4'h0;
        maddr    = 32'h0;
        mwd      = 32'h0;
        @(negedge i_clk);
        i_req    = 1'b1;
        i_we     = we;
        i_funct3 = f3;
        i_addr   = addr;
        i_wdata  = wd;
        #1;
        check("stall_accept", {31'b0, o_stall}, 32'd1);
        for (cyc = 1; cyc <= 50; cyc++) begin
            @(negedge i_clk);
            i_req       = 1'b0;
            i_mem_ack   = 1'b0;
            i_mem_rdata = 32'h0;
            if (o_mem_req) begin
                if (req_cyc == 0) begin
                    strb  = o_mem_wstrb;
                    maddr = o_mem_addr;
                    mwd   = o_mem_wdata;
                end
                i_mem_ack   = (req_cyc == ack_at);
                i_mem_rdata = mrd;
                req_cyc++;
            end
            if (o_done) begin
                done_cyc = cyc;
                flt      = o_fault;
                check("stall_done", {31'b0, o_stall}, 32'd0);
                break;
            end
        end
        if (done_cyc < 0) begin
            check("watchdog", 32'd1, 32'd0);
        end
    endtask

    int          dc;
    int          rc;
    logic        fl;
    logic [3:0]  sb;
    logic [31:0] ma;
    logic [31:0] md;

    initial begin
        i_rst       = 1'b1;
        i_req       = 1'b0;
        i_we        = 1'b0;
        i_funct3    = 3'b000;
        i_addr      = 32'h0;
        i_wdata     = 32'h0;
        i_mem_ack   = 1'b0;
        i_mem_rdata = 32'h0;
        repeat (2) @(negedge i_clk);
        check("rst_req",   {31'b0, o_mem_req}, 32'd0);
        check("rst_done",  {31'b0, o_done},    32'd0);
        check("rst_stall", {31'b0, o_stall},   32'd0);
        check("rst_fault", {31'b0, o_fault},   32'd0);
        check("rst_rdata", o_rdata,            32'h0);
        check("rst_wstrb", {28'b0, o_mem_wstrb}, 32'h0);
        i_rst = 1'b0;

        run(1'b0, LSU_W, 32'h100, 32'h0, 32'hDEADBEEF, 0, dc, rc, fl, sb, ma, md);
        check("lw_done_cyc", dc, 2);
        check("lw_req_cyc",  rc, 1);
        check("lw_fault",    {31'b0, fl}, 32'd0);
        check("lw_rdata",    o_rdata, 32'hDEADBEEF);
        check("lw_addr",     ma, 32'h100);
        check("lw_strb",     {28'b0, sb}, 32'h0);

        run(1'b0, LSU_B, 32'h103, 32'h0, 32'h80FF0000, 0, dc, rc, fl, sb, ma, md);
        check("lb_rdata", o_rdata, 32'hFFFFFF80);
        check("lb_addr",  ma, 32'h100);
        run(1'b0, LSU_BU, 32'h103, 32'h0, 32'h80FF0000, 0, dc, rc, fl, sb, ma, md);
        check("lbu_rdata", o_rdata, 32'h00000080);
        run(1'b0, LSU_H, 32'h102, 32'h0, 32'h80FF0000, 0, dc, rc, fl, sb, ma, md);
        check("lh_rdata", o_rdata, 32'hFFFF80FF);
        run(1'b0, LSU_HU, 32'h102, 32'h0, 32'h80FF0000, 0, dc, rc, fl, sb, ma, md);
        check("lhu_rdata", o_rdata, 32'h000080FF);
        run(1'b0, LSU_B, 32'h101, 32'h0, 32'h00007F00, 0, dc, rc, fl, sb, ma, md);
        check("lb_pos_rdata", o_rdata, 32'h0000007F);

        run(1'b1, LSU_H, 32'h102, 32'h1234ABCD, 32'h0, 0, dc, rc, fl, sb, ma, md);
        check("sh_addr",  ma, 32'h100);
        check("sh_strb",  {28'b0, sb}, 32'hC);
        check("sh_wdata", md, 32'hABCDABCD);
        check("sh_done",  dc, 2);
        check("sh_fault", {31'b0, fl}, 32'd0);
        check("sh_rdata_hold", o_rdata, 32'h0000007F);

        run(1'b1, LSU_B, 32'h205, 32'h000000A5, 32'h0, 0, dc, rc, fl, sb, ma, md);
        check("sb_addr",  ma, 32'h204);
        check("sb_strb",  {28'b0, sb}, 32'h2);
        check("sb_wdata", md, 32'hA5A5A5A5);
        run(1'b1, LSU_W, 32'h300, 32'h11223344, 32'h0, 0, dc, rc, fl, sb, ma, md);
        check("sw_strb",  {28'b0, sb}, 32'hF);
        check("sw_wdata", md, 32'h11223344);

        run(1'b1, LSU_W, 32'h101, 32'h55, 32'h0, 0, dc, rc, fl, sb, ma, md);
        check("sw_mis_req",   rc, 0);
        check("sw_mis_done",  dc, 1);
        check("sw_mis_fault", {31'b0, fl}, 32'd1);
        check("sw_mis_rdata", o_rdata, 32'h0000007F);
        run(1'b0, LSU_H, 32'h101, 32'h0, 32'h0, 0, dc, rc, fl, sb, ma, md);
        check("lh_mis_fault", {31'b0, fl}, 32'd1);
        check("lh_mis_req",   rc, 0);
        run(1'b0, LSU_W, 32'h102, 32'h0, 32'h0, 0, dc, rc, fl, sb, ma, md);
        check("lw_mis_fault", {31'b0, fl}, 32'd1);
        run(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, dc, rc, fl, sb, ma, md);
        check("f3_011_fault", {31'b0, fl}, 32'd1);
        check("f3_011_req",   rc, 0);
        run(1'b1, LSU_BU, 32'h100, 32'h0, 32'h0, 0, dc, rc, fl, sb, ma, md);
        check("sbu_fault", {31'b0, fl}, 32'd1);
        run(1'b0, LSU_HU, 32'h102, 32'h0, 32'h1234, 0, dc, rc, fl, sb, ma, md);
        check("lhu_ok_fault", {31'b0, fl}, 32'd0);

        run(1'b0, LSU_W, 32'h400, 32'h0, 32'hAAAA5555, -1, dc, rc, fl, sb, ma, md);
        check("tmo_req_cyc", rc, 5);
        check("tmo_done",    dc, 6);
        check("tmo_fault",   {31'b0, fl}, 32'd1);
        check("tmo_rdata",   o_rdata, 32'h00000000);
        run(1'b0, LSU_W, 32'h400, 32'h0, 32'hAAAA5555, 4, dc, rc, fl, sb, ma, md);
        check("late_req_cyc", rc, 5);
        check("late_done",    dc, 6);
        check("late_fault",   {31'b0, fl}, 32'd0);
        check("late_rdata",   o_rdata, 32'hAAAA5555);

        @(negedge i_clk);
        i_req    = 1'b1;
        i_we     = 1'b0;
        i_funct3 = LSU_W;
        i_addr   = 32'h200;
        @(negedge i_clk);
        i_req = 1'b0;
        repeat (2) @(negedge i_clk);
        check("rst_mid_req_before", {31'b0, o_mem_req}, 32'd1);
        #2;
        i_rst = 1'b1;
        #1;
        check("rst_mid_req",   {31'b0, o_mem_req}, 32'd0);
        check("rst_mid_stall", {31'b0, o_stall},   32'd0);
        check("rst_mid_done",  {31'b0, o_done},    32'd0);
        check("rst_mid_rdata", o_rdata,            32'h0);
        @(negedge i_clk);
        i_rst = 1'b0;
        run(1'b0, LSU_W, 32'h200, 32'h0, 32'hCAFEF00D, 1, dc, rc, fl, sb, ma, md);
        check("post_rst_done",  dc, 3);
        check("post_rst_fault", {31'b0, fl}, 32'd0);
        check("post_rst_rdata", o_rdata, 32'hCAFEF00D);
        check("post_rst_addr",  ma, 32'h200);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
